// File: rtl/hit_judge.sv
// Grades each player hit against the latched goal note (PERFECT/GOOD/MISS) and keeps combo/score.
// Latency: hit or timeout sampled at cycle N -> judge_valid and score update at N+2.
// No backpressure: one-cycle pulses in and out; a goal arriving while armed queues in a 1-deep slot.
// Optional build macro HIT_JUDGE_EARLY_LATE_EN adds the judge_late, early_cnt and late_cnt outputs.
module hit_judge #(
    parameter int CLK_W    = 32,
    parameter int OCT_W    = 3,
    parameter int NOTE_W   = 3,
    parameter int SCORE_W  = 21,
    parameter int PERF_WIN = 25,
    parameter int GOOD_WIN = 75,
    parameter int PERF_PTS = 3,
    parameter int GOOD_PTS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [1:0]         difficulty,
    input  logic [CLK_W-1:0]   system_clock,
    input  logic               goal_valid,
    input  logic [OCT_W-1:0]   goal_octave,
    input  logic [NOTE_W-1:0]  goal_note,
    input  logic [CLK_W-1:0]   goal_clock,
    input  logic               goal_last,
    input  logic               hit_valid,
    input  logic [OCT_W-1:0]   hit_octave,
    input  logic [NOTE_W-1:0]  hit_note,
    input  logic [CLK_W-1:0]   hit_clock,
    output logic               judge_valid,
    output logic [1:0]         judge_grade,
    output logic [SCORE_W-1:0] combo,
    output logic [SCORE_W-1:0] max_combo,
    output logic [SCORE_W-1:0] base_score,
    output logic               armed,
    output logic               done
`ifdef HIT_JUDGE_EARLY_LATE_EN
    ,
    output logic               judge_late,
    output logic [SCORE_W-1:0] early_cnt,
    output logic [SCORE_W-1:0] late_cnt
`endif
);

    localparam logic [1:0] GR_MISS = 2'd0;
    localparam logic [1:0] GR_GOOD = 2'd1;
    localparam logic [1:0] GR_PERF = 2'd2;

    localparam logic [CLK_W-1:0] PERF_BASE = CLK_W'(PERF_WIN);
    localparam logic [CLK_W-1:0] GOOD_BASE = CLK_W'(GOOD_WIN);
    localparam logic [CLK_W-1:0] WIN_MIN   = CLK_W'(1);
    localparam logic [SCORE_W:0] PERF_ADD  = (SCORE_W+1)'(PERF_PTS);
    localparam logic [SCORE_W:0] GOOD_ADD  = (SCORE_W+1)'(GOOD_PTS);
    localparam logic [SCORE_W-1:0] SAT    = '1;

    typedef enum logic [1:0] {IDLE, ARMED, JUDGE, DONE} state_t;

    state_t state, state_n;

    // en low behaves exactly like reset
    logic clear;
    assign clear = rst || !en;

    // Latched goal, pending goal slot and latched hit
    logic [OCT_W-1:0]  g_oct, p_oct, h_oct;
    logic [NOTE_W-1:0] g_note, p_note, h_note;
    logic [CLK_W-1:0]  g_clk, p_clk, h_clk;
    logic              g_last, p_last, p_vld;
    logic              miss_q;

    // FSM control strobes
    logic goal_from_in, goal_from_pend, pend_from_in, pend_clr;
    logic hit_from_in, force_miss, judge_now;

    // Windows shrink with difficulty but never collapse to zero
    logic [CLK_W-1:0] perf_win, good_win;
    always_comb begin
        perf_win = PERF_BASE >> difficulty;
        good_win = GOOD_BASE >> difficulty;
        if (perf_win == '0) perf_win = WIN_MIN;
        if (good_win == '0) good_win = WIN_MIN;
    end

    // Timeout: tick distance past the goal, read as signed so wrap is seamless
    logic [CLK_W-1:0] age;
    logic             timeout;
    assign age     = system_clock - g_clk;
    assign timeout = $signed(age) > $signed(good_win);

    // Grade of the latched hit against the latched goal
    logic [CLK_W-1:0] d, mag;
    logic             pitch_ok;
    logic [1:0]       grade_c;
    always_comb begin
        d        = h_clk - g_clk;
        mag      = d[CLK_W-1] ? (~d + WIN_MIN) : d;
        pitch_ok = (h_oct == g_oct) && (h_note == g_note);
        grade_c  = GR_MISS;
        if (!miss_q && pitch_ok) begin
            if (mag <= perf_win)      grade_c = GR_PERF;
            else if (mag <= good_win) grade_c = GR_GOOD;
        end
    end

    // Next combo / max / score values for the current judgement
    logic               hit_ok;
    logic [SCORE_W-1:0] combo_n, max_n, score_n;
    logic [SCORE_W:0]   score_sum;
    always_comb begin
        hit_ok    = (grade_c != GR_MISS);
        combo_n   = '0;
        if (hit_ok) combo_n = (combo == SAT) ? combo : combo + SCORE_W'(1);
        max_n     = (combo_n > max_combo) ? combo_n : max_combo;
        score_sum = {1'b0, base_score} + ((grade_c == GR_PERF) ? PERF_ADD : GOOD_ADD);
        score_n   = base_score;
        if (hit_ok) score_n = score_sum[SCORE_W] ? SAT : score_sum[SCORE_W-1:0];
    end

    // State register
    always_ff @(posedge clk) begin
        if (clear) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state and control decode; a hit beats both timeout and a new goal
    always_comb begin
        state_n        = state;
        goal_from_in   = 1'b0;
        goal_from_pend = 1'b0;
        pend_from_in   = 1'b0;
        pend_clr       = 1'b0;
        hit_from_in    = 1'b0;
        force_miss     = 1'b0;
        judge_now      = 1'b0;
        armed          = (state == ARMED);
        done           = (state == DONE);
        case (state)
            IDLE: begin
                if (goal_valid) begin
                    goal_from_in = 1'b1;
                    state_n      = ARMED;
                end
            end
            ARMED: begin
                if (hit_valid) begin
                    hit_from_in  = 1'b1;
                    pend_from_in = goal_valid;
                    state_n      = JUDGE;
                end else if (goal_valid) begin
                    force_miss   = 1'b1;
                    pend_from_in = 1'b1;
                    state_n      = JUDGE;
                end else if (timeout) begin
                    force_miss   = 1'b1;
                    state_n      = JUDGE;
                end
            end
            JUDGE: begin
                judge_now = 1'b1;
                pend_clr  = 1'b1;
                if (g_last) begin
                    state_n = DONE;
                end else if (goal_valid) begin
                    // a goal arriving now is newer than the slot, so it replaces it
                    goal_from_in = 1'b1;
                    state_n      = ARMED;
                end else if (p_vld) begin
                    goal_from_pend = 1'b1;
                    state_n        = ARMED;
                end else begin
                    state_n = IDLE;
                end
            end
            DONE:    ;
            default: state_n = IDLE;
        endcase
    end

    // Goal, pending slot and hit capture
    always_ff @(posedge clk) begin
        if (clear) begin
            g_oct <= '0; g_note <= '0; g_clk <= '0; g_last <= 1'b0;
            p_oct <= '0; p_note <= '0; p_clk <= '0; p_last <= 1'b0; p_vld <= 1'b0;
            h_oct <= '0; h_note <= '0; h_clk <= '0; miss_q <= 1'b0;
        end else begin
            if (goal_from_in) begin
                g_oct <= goal_octave; g_note <= goal_note;
                g_clk <= goal_clock;  g_last <= goal_last;
            end else if (goal_from_pend) begin
                g_oct <= p_oct; g_note <= p_note; g_clk <= p_clk; g_last <= p_last;
            end
            if (pend_from_in) begin
                p_vld <= 1'b1;
                p_oct <= goal_octave; p_note <= goal_note;
                p_clk <= goal_clock;  p_last <= goal_last;
            end else if (pend_clr) begin
                p_vld <= 1'b0;
            end
            if (hit_from_in) begin
                h_oct <= hit_octave; h_note <= hit_note; h_clk <= hit_clock;
                miss_q <= 1'b0;
            end else if (force_miss) begin
                miss_q <= 1'b1;
            end
        end
    end

    // Result pulse and running combo / score
    always_ff @(posedge clk) begin
        if (clear) begin
            judge_valid <= 1'b0;
            judge_grade <= GR_MISS;
            combo       <= '0;
            max_combo   <= '0;
            base_score  <= '0;
        end else begin
            judge_valid <= judge_now;
            if (judge_now) begin
                judge_grade <= grade_c;
                combo       <= combo_n;
                max_combo   <= max_n;
                base_score  <= score_n;
            end
        end
    end

`ifdef HIT_JUDGE_EARLY_LATE_EN
    // Late means strictly after the goal tick; an exact hit counts as early
    logic d_late;
    assign d_late = !d[CLK_W-1] && (d != '0);

    // Early/late tally of successful hits
    always_ff @(posedge clk) begin
        if (clear) begin
            judge_late <= 1'b0;
            early_cnt  <= '0;
            late_cnt   <= '0;
        end else if (judge_now) begin
            judge_late <= hit_ok && d_late;
            if (hit_ok && d_late && late_cnt != SAT)    late_cnt  <= late_cnt + SCORE_W'(1);
            if (hit_ok && !d_late && early_cnt != SAT)  early_cnt <= early_cnt + SCORE_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hit_judge.sv
// Bench for hit_judge: directed and randomized goal/hit scenarios with a queued expected-result model.
// Latency: expected results carry the cycle at which judge_valid must appear (stimulus cycle + 2).
// Backpressure: none; the monitor pops one expectation per judge_valid pulse.
module tb_hit_judge;
    localparam int CLK_W = 32;
    localparam int SW    = 21;

    logic           clk = 1'b0;
    logic           rst, en;
    logic [1:0]     difficulty;
    logic [CLK_W-1:0] system_clock;
    logic           goal_valid, goal_last;
    logic [2:0]     goal_octave, goal_note;
    logic [CLK_W-1:0] goal_clock;
    logic           hit_valid;
    logic [2:0]     hit_octave, hit_note;
    logic [CLK_W-1:0] hit_clock;
    logic           judge_valid;
    logic [1:0]     judge_grade;
    logic [SW-1:0]  combo, max_combo, base_score;
    logic           armed, done;
`ifdef HIT_JUDGE_EARLY_LATE_EN
    logic           judge_late;
    logic [SW-1:0]  early_cnt, late_cnt;
`endif

    always #5 clk = ~clk;

    hit_judge dut (
        .clk(clk), .rst(rst), .en(en), .difficulty(difficulty), .system_clock(system_clock),
        .goal_valid(goal_valid), .goal_octave(goal_octave), .goal_note(goal_note),
        .goal_clock(goal_clock), .goal_last(goal_last),
        .hit_valid(hit_valid), .hit_octave(hit_octave), .hit_note(hit_note), .hit_clock(hit_clock),
        .judge_valid(judge_valid), .judge_grade(judge_grade), .combo(combo),
        .max_combo(max_combo), .base_score(base_score), .armed(armed), .done(done)
`ifdef HIT_JUDGE_EARLY_LATE_EN
        , .judge_late(judge_late), .early_cnt(early_cnt), .late_cnt(late_cnt)
`endif
    );

    typedef struct {
        int grade; int combo; int maxc; int score; int late; int early_n; int late_n; int cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    // Reference model state
    int          m_combo, m_max, m_score, m_early, m_late, m_diff;
    logic [2:0]  m_goct, m_gnote;
    logic [31:0] m_gclk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int win(input int base, input int diff);
        int w;
        w = base >> diff;
        return (w < 1) ? 1 : w;
    endfunction

    function automatic longint signed_diff(input logic [31:0] hclk);
        logic [31:0] t;
        t = hclk - m_gclk;
        return longint'($signed(t));
    endfunction

    function automatic int ref_grade(input logic [2:0] oct, input logic [2:0] note, input logic [31:0] hclk);
        longint d, mag;
        if (oct != m_goct || note != m_gnote) return 0;
        d   = signed_diff(hclk);
        mag = (d < 0) ? -d : d;
        if (mag <= win(25, m_diff)) return 2;
        if (mag <= win(75, m_diff)) return 1;
        return 0;
    endfunction

    task automatic model_clear();
        m_combo = 0; m_max = 0; m_score = 0; m_early = 0; m_late = 0;
    endtask

    task automatic expect_result(input int grade, input int late, input int at);
        exp_t e;
        if (grade == 0) m_combo = 0;
        else begin
            m_combo++;
            m_score += (grade == 2) ? 3 : 1;
            if (late != 0) m_late++; else m_early++;
        end
        if (m_combo > m_max) m_max = m_combo;
        e.grade = grade; e.combo = m_combo; e.maxc = m_max; e.score = m_score;
        e.late = (grade != 0) ? late : 0; e.early_n = m_early; e.late_n = m_late; e.cyc = at;
        sbq.push_back(e);
    endtask

    // Monitor: every judge_valid pulse must match the oldest expectation, on time
    always @(negedge clk) begin
        if (sbq.size() > 0 && sbq[0].cyc < cyc) begin
            checks++; errors++;
            $display("FAIL missing_judge: got none, expected judge_valid at cycle %0d", sbq[0].cyc);
            void'(sbq.pop_front());
        end
        if (judge_valid) begin
            if (sbq.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_judge: got judge_valid grade %0d, expected none (cycle %0d)", judge_grade, cyc);
            end else begin
                mon_e = sbq.pop_front();
                chk("judge_cycle", cyc, mon_e.cyc);
                chk("judge_grade", judge_grade, mon_e.grade);
                chk("combo", combo, mon_e.combo);
                chk("max_combo", max_combo, mon_e.maxc);
                chk("base_score", base_score, mon_e.score);
`ifdef HIT_JUDGE_EARLY_LATE_EN
                chk("judge_late", judge_late, mon_e.late);
                chk("early_cnt", early_cnt, mon_e.early_n);
                chk("late_cnt", late_cnt, mon_e.late_n);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_goal(input logic [2:0] oct, input logic [2:0] note, input logic [31:0] gclk, input logic last);
        goal_octave = oct; goal_note = note; goal_clock = gclk; goal_last = last;
        goal_valid = 1'b1; system_clock = gclk;
        m_goct = oct; m_gnote = note; m_gclk = gclk;
        tick();
        goal_valid = 1'b0;
    endtask

    task automatic send_hit(input logic [2:0] oct, input logic [2:0] note, input logic [31:0] hclk, input bit exp_it);
        hit_octave = oct; hit_note = note; hit_clock = hclk; hit_valid = 1'b1;
        if (exp_it) expect_result(ref_grade(oct, note, hclk), (signed_diff(hclk) > 0) ? 1 : 0, cyc + 2);
        tick();
        hit_valid = 1'b0;
    endtask

    task automatic set_diff(input int dd);
        m_diff = dd; difficulty = 2'(dd);
    endtask

    task automatic hit_case(input logic [2:0] go, input logic [2:0] gn, input logic [31:0] gc, input logic last,
                            input logic [2:0] ho, input logic [2:0] hn, input logic [31:0] hc, input int k);
        send_goal(go, gn, gc, last);
        chk("armed_after_goal", armed, 1);
        repeat (k) tick();
        send_hit(ho, hn, hc, 1'b1);
        tick();
    endtask

    task automatic timeout_case(input logic [31:0] gc);
        logic [31:0] gw;
        gw = 32'(win(75, m_diff));
        send_goal(3'(($urandom)), 3'(($urandom)), gc, 1'b0);
        system_clock = gc + gw;
        tick();
        chk("armed_at_window_edge", armed, 1);
        system_clock = gc + gw + 32'd1;
        expect_result(0, 0, cyc + 2);
        tick();
        tick();
        chk("idle_after_timeout", armed, 0);
    endtask

    task automatic tie_case(input logic [31:0] gc);
        logic [31:0] gw;
        gw = 32'(win(75, m_diff));
        send_goal(3'd2, 3'd5, gc, 1'b0);
        system_clock = gc + gw + 32'd1;
        send_hit(3'd2, 3'd5, gc + 32'd1, 1'b1);
        tick();
        chk("idle_after_tie", armed, 0);
    endtask

    task automatic overlap_case(input bit overwrite);
        logic [31:0] gc;
        logic [2:0]  n;
        gc = $urandom;
        n  = 3'($urandom);
        send_goal(3'd1, n, gc, 1'b0);
        expect_result(0, 0, cyc + 2);
        send_goal(3'd1, n + 3'd1, gc + 32'd7, 1'b0);
        if (overwrite) send_goal(3'd1, n + 3'd2, gc + 32'd9, 1'b0);
        else           tick();
        chk("armed_on_pending", armed, 1);
        send_hit(3'd1, m_gnote, m_gclk + 32'($urandom_range(0, 10)), 1'b1);
        tick();
    endtask

    initial begin
        logic [31:0] gc;
        int          sc;
        rst = 1'b1; en = 1'b1; difficulty = 2'd0; system_clock = '0;
        goal_valid = 1'b0; goal_octave = '0; goal_note = '0; goal_clock = '0; goal_last = 1'b0;
        hit_valid = 1'b0; hit_octave = '0; hit_note = '0; hit_clock = '0;
        model_clear(); set_diff(0);
        m_goct = '0; m_gnote = '0; m_gclk = '0;
        repeat (3) tick();
        chk("reset_judge_valid", judge_valid, 0);
        chk("reset_combo", combo, 0);
        chk("reset_max_combo", max_combo, 0);
        chk("reset_score", base_score, 0);
        chk("reset_armed", armed, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        tick();

        // Exact hit, late GOOD, then the same late hit at a harder difficulty
        hit_case(3'd4, 3'd0, 32'd1000, 1'b0, 3'd4, 3'd0, 32'd1000, 1);
        hit_case(3'd4, 3'd0, 32'd1000, 1'b0, 3'd4, 3'd0, 32'd1050, 2);
        set_diff(2);
        hit_case(3'd4, 3'd0, 32'd1000, 1'b0, 3'd4, 3'd0, 32'd1050, 1);
        set_diff(0);

        // Build combo to 5, then break it with a wrong pitch
        for (int i = 0; i < 5; i++)
            hit_case(3'd4, 3'd0, 32'(3000 + i * 100), 1'b0, 3'd4, 3'd0, 32'(3000 + i * 100 - 20), 1);
        hit_case(3'd4, 3'd0, 32'd5000, 1'b0, 3'd4, 3'd1, 32'd5000, 1);
        chk("max_combo_kept", max_combo, 5);

        timeout_case(32'd6000);
        tie_case(32'd7000);
        overlap_case(1'b0);
        overlap_case(1'b1);

        // Timestamps straddling wrap
        set_diff(1);
        hit_case(3'd3, 3'd3, 32'hFFFF_FFF6, 1'b0, 3'd3, 3'd3, 32'd5, 0);
        set_diff(0);

        // Hit while idle is ignored
        send_hit(3'd4, 3'd0, 32'd100, 1'b0);
        tick();

        // Reset during the judge cycle discards the pending result
        send_goal(3'd4, 3'd0, 32'd9000, 1'b0);
        send_hit(3'd4, 3'd0, 32'd9000, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        chk("rst_drops_judge", judge_valid, 0);
        chk("rst_combo", combo, 0);
        tick();

        // Randomized rounds
        for (int it = 0; it < 150; it++) begin
            set_diff($urandom_range(0, 3));
            gc = $urandom;
            sc = $urandom_range(0, 9);
            if (sc < 6) begin
                logic [2:0] o, n, hn;
                o  = 3'($urandom);
                n  = 3'($urandom);
                hn = ($urandom_range(0, 3) == 0) ? n + 3'd1 : n;
                hit_case(o, n, gc, 1'b0, o, hn, gc + 32'($urandom_range(0, 180)) - 32'd90,
                         $urandom_range(0, 3));
            end else if (sc == 6) timeout_case(gc);
            else if (sc == 7)     tie_case(gc);
            else                  overlap_case(sc == 9);
        end

        // Final note of track, then DONE ignores further traffic until en drops
        set_diff(0);
        hit_case(3'd5, 3'd6, 32'd20000, 1'b1, 3'd5, 3'd6, 32'd20003, 1);
        chk("done_after_last", done, 1);
        chk("not_armed_in_done", armed, 0);
        send_goal(3'd1, 3'd1, 32'd30000, 1'b0);
        send_hit(3'd1, 3'd1, 32'd30000, 1'b0);
        repeat (2) tick();
        chk("done_held", done, 1);
        en = 1'b0;
        tick();
        model_clear();
        chk("en_low_done", done, 0);
        chk("en_low_combo", combo, 0);
        chk("en_low_max", max_combo, 0);
        chk("en_low_score", base_score, 0);
        en = 1'b1;
        repeat (4) tick();
        chk("scoreboard_drained", sbq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end
endmodule
